// File: rtl/range_bin_accumulator.sv
// Coherent range-bin accumulator: bins each clock's sample pair after a trigger,
// sums NBINS bins over several shots in on-chip RAM, then streams the profile out.
`timescale 1ns/1ps

module range_bin_accumulator #(
  parameter int SAMPLE_W = 16,
  parameter int NBINS    = 256,
  parameter int AW       = 8,
  parameter int ACC_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] x0_i,
  input  logic [SAMPLE_W-1:0] x0z_i,
  input  logic                trig_i,
  input  logic                start_i,
  input  logic [15:0]         num_pulses_i,
  output logic [ACC_W-1:0]    dout_o,
  output logic                dout_valid_o,
  output logic                dout_last_o,
  input  logic                dout_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam logic [AW-1:0] LAST_BIN = AW'(NBINS - 1);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DUMP} state_t;

  state_t state;

  logic                trig_q;
  logic                trig_edge;
  logic [15:0]         num_pulses;
  logic [15:0]         shot_cnt;
  logic                more_shots;
  logic [AW-1:0]       bin_k;

  logic signed [SAMPLE_W:0] pair_sum;
  logic [ACC_W-1:0]    pair_ext;

  logic                wr_en;
  logic                wr_first;
  logic [AW-1:0]       wr_addr;
  logic [ACC_W-1:0]    wr_sum;

  logic [ACC_W-1:0]    mem [NBINS];
  logic [ACC_W-1:0]    rd_data;
  logic [AW-1:0]       rd_addr;

  logic [AW-1:0]       rd_ptr;
  logic                all_issued;
  logic                rd_vld;
  logic                rd_last;
  logic [ACC_W-1:0]    skid_data;
  logic                skid_last;
  logic                skid_valid;
  logic                xfer;
  logic [1:0]          pending;
  logic                issue;

  assign trig_edge  = trig_i & ~trig_q;
  assign pair_sum   = $signed(x0_i) + $signed(x0z_i);
  assign pair_ext   = {{(ACC_W-SAMPLE_W-1){pair_sum[SAMPLE_W]}}, pair_sum};
  assign more_shots = ({1'b0, shot_cnt} + 17'd1) < {1'b0, num_pulses};

  // Readout never has more than two words held or in flight beyond what is leaving,
  // so the output register plus one skid word can absorb any stall.
  assign xfer    = dout_valid_o & dout_ready_i;
  assign pending = 2'(dout_valid_o) + 2'(skid_valid) + 2'(rd_vld) - 2'(xfer);
  assign issue   = (state == DUMP) && !all_issued && (pending <= 2'd1);
  assign rd_addr = (state == ACCUM) ? bin_k : rd_ptr;

  // RAM has no reset; the first shot of every run overwrites each bin.
  always_ff @(posedge clk_i) begin
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] <= wr_first ? wr_sum : rd_data + wr_sum;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      trig_q       <= 1'b0;
      num_pulses   <= '0;
      shot_cnt     <= '0;
      bin_k        <= '0;
      wr_en        <= 1'b0;
      wr_first     <= 1'b0;
      wr_addr      <= '0;
      wr_sum       <= '0;
      rd_ptr       <= '0;
      all_issued   <= 1'b0;
      rd_vld       <= 1'b0;
      rd_last      <= 1'b0;
      skid_data    <= '0;
      skid_last    <= 1'b0;
      skid_valid   <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      dout_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      trig_q <= trig_i;
      done_o <= 1'b0;
      wr_en  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_i) begin
            num_pulses <= (num_pulses_i == 16'd0) ? 16'd1 : num_pulses_i;
            shot_cnt   <= '0;
            overrun_o  <= 1'b0;
            busy_o     <= 1'b1;
            state      <= ARM;
          end
        end

        ARM: begin
          if (trig_edge) begin
            bin_k <= '0;
            state <= ACCUM;
          end
        end

        ACCUM: begin
          // Read of bin_k lands in rd_data now; the add and write happen next cycle.
          wr_en    <= 1'b1;
          wr_addr  <= bin_k;
          wr_sum   <= pair_ext;
          wr_first <= (shot_cnt == 16'd0);
          bin_k    <= bin_k + AW'(1);
          if (trig_edge) begin
            overrun_o <= 1'b1;
          end
          if (bin_k == LAST_BIN) begin
            if (more_shots) begin
              shot_cnt <= shot_cnt + 16'd1;
              state    <= ARM;
            end else begin
              rd_ptr     <= '0;
              all_issued <= 1'b0;
              rd_vld     <= 1'b0;
              state      <= DUMP;
            end
          end
        end

        DUMP: begin
          if (trig_edge) begin
            overrun_o <= 1'b1;
          end
          if (issue) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (rd_ptr == LAST_BIN) begin
              all_issued <= 1'b1;
            end
          end
          rd_vld  <= issue;
          rd_last <= (rd_ptr == LAST_BIN);

          if (!dout_valid_o || dout_ready_i) begin
            if (skid_valid) begin
              dout_o       <= skid_data;
              dout_last_o  <= skid_last;
              dout_valid_o <= 1'b1;
              skid_valid   <= rd_vld;
              skid_data    <= rd_data;
              skid_last    <= rd_last;
            end else if (rd_vld) begin
              dout_o       <= rd_data;
              dout_last_o  <= rd_last;
              dout_valid_o <= 1'b1;
            end else begin
              dout_valid_o <= 1'b0;
              dout_last_o  <= 1'b0;
            end
          end else if (rd_vld) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data;
            skid_last  <= rd_last;
          end

          if (xfer && dout_last_o) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/range_bin_accumulator.md
Name: range_bin_accumulator

Overview:
- Sits directly downstream of user_logic_signal_processing. Consumes its filtered sample pair (y0_o/y0z_o, two samples per clock) and its trigger output.
- On each laser trigger, sums each clock's sample pair into one range bin, NBINS bins per shot.
- Accumulates the bins coherently over a programmed number of shots in on-chip RAM.
- Streams the accumulated profile out over a valid/ready interface for DMA/host readout.

Parameters:
- SAMPLE_W, 16: width of each input sample, two's complement.
- NBINS, 256: range bins per shot; one bin per clock.
- AW, 8: bin address width; NBINS must equal 2**AW.
- ACC_W, 32: accumulator/RAM word width, two's complement.

Ports:
- clk_i  in  1  sample clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- x0_i  in  SAMPLE_W  even sample of current pair (signed).
- x0z_i  in  SAMPLE_W  odd sample of current pair (signed).
- trig_i  in  1  shot trigger; rising edge significant.
- start_i  in  1  one-cycle pulse; begins an accumulation run.
- num_pulses_i  in  16  shots per run; sampled on accepted start_i.
- dout_o  out  ACC_W  accumulated bin value.
- dout_valid_o  out  1  dout_o valid.
- dout_last_o  out  1  high with bin NBINS-1.
- dout_ready_i  in  1  downstream accepts dout_o.
- busy_o  out  1  run in progress (not IDLE).
- done_o  out  1  one-cycle pulse after last bin accepted.
- overrun_o  out  1  sticky: trigger edge arrived while not armed during a run.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. RAM contents undefined and not cleared.
- Trigger edge: trig_i high and trig_i registered low on the previous edge. A level held high counts once.
- Pair sum: s = sext(x0_i) + sext(x0z_i), SAMPLE_W+1 bits, sign-extended to ACC_W.
- Accumulation wraps modulo 2**ACC_W; no saturation.
- num_pulses_i = 0 is treated as 1.
- State machine:
  - IDLE: start_i latches num_pulses_i, clears shot counter and overrun_o, goes to ARM. busy_o=1 from the next cycle. start_i is ignored in every state except IDLE.
  - ARM: trigger edge seen at edge t goes to ACCUM. Sample pairs present at edges t+1 .. t+NBINS go to bins 0 .. NBINS-1.
  - ACCUM:
    - Bin counter k runs 0..NBINS-1, one bin per clock.
    - Shot 0 writes s directly (implicit clear). Later shots write RAM[k]+s.
    - Read-modify-write pipeline: read address k issued at cycle k, add and write at cycle k+1. No hazard, since addresses are distinct within a shot and ARM takes at least 1 cycle between shots.
    - After bin NBINS-1: if shot count+1 < num_pulses, increment shot count and go to ARM. Otherwise go to DUMP after the final write completes.
  - DUMP:
    - Reads bins 0..NBINS-1 in order.
    - dout_valid_o first asserts 2 cycles after entering DUMP (1-cycle RAM read latency plus output register).
    - dout_o, dout_valid_o and dout_last_o hold stable while dout_valid_o=1 and dout_ready_i=0.
    - A transfer occurs when valid&&ready. With ready held high, one bin is transferred per clock with no bubbles; a prefetch/skid register is required.
    - After the transfer with dout_last_o=1, go to IDLE, pulse done_o for 1 cycle, and drop busy_o the same cycle.
- Trigger edges during ACCUM or DUMP are ignored and set overrun_o. overrun_o stays set until the next accepted start_i or reset. Edges in IDLE are ignored and do not set overrun_o.
- start_i and a trigger edge in the same cycle in IDLE: start is accepted, the trigger is ignored (not armed yet).
- Reset mid-run: returns to IDLE immediately. Any partial dout transfer is abandoned and dout_valid_o drops asynchronously.

Test Plan:
- Single shot, sequence: num_pulses=1, x0=k, x0z=2k for bin k, ready=1.
  - 256 words out, dout[k]=3k.
  - dout_last_o only on word 255; done_o 1 cycle after word 255.
- Coherent sum, signed: num_pulses=4, constant x0=-1000, x0z=+200, four well-spaced triggers.
  - Every bin = -3200 (0xFFFFF380).
  - busy_o high from start+1 until done_o.
- Backpressure: after a 1-shot run, drive dout_ready_i as a pseudo-random 50% pattern.
  - Output sequence identical to the ready=1 case, with no duplicated or dropped bins.
  - dout_o stable across every stall cycle.
- Overrun:
  - A second trigger 100 cycles into ACCUM sets overrun_o=1 and bin data is unaffected.
  - A trigger held high across 3 cycles in ARM starts only one shot.
  - overrun_o clears on the next start_i.
- Wrap: ACC_W=18 build, num_pulses=3, x0=x0z=32767 (sum 65534).
  - Bins = 196602 mod 2^18 = 196602.
  - num_pulses=5 gives 327670-262144 = 65526.
- Reset mid-DUMP: assert rst_i at bin 100.
  - Outputs 0 and IDLE immediately.
  - A new start_i with num_pulses=0 runs one shot and produces correct fresh bins with no stale accumulation.
